// File: rtl/smp_loader_pkg.sv
// Shared constants and types for the sample-memory loader.
// The RAM bound is also used by the playback reader.
package smp_loader_pkg;

  localparam int         MAX_ADR_DEF     = 12586;
  localparam int         TIMEOUT_CYC_DEF = 2_000_000;
  localparam logic [7:0] SYNC_BYTE       = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_DAT_L,
    ST_DAT_H,
    ST_CSUM
  } ld_state_e;

endpackage

// File: rtl/smp_loader_if.sv
// UART byte input and sample-RAM write / status bundle of the loader.
// The byte source is the master; the loader is the slave.
interface smp_loader_if;

  logic [7:0]  uart_in;
  logic        uart_rcv;
  logic [15:0] adr_ram;
  logic [15:0] data_ram;
  logic        we_ram;
  logic        load_active;
  logic        done;
  logic        err;
  logic [15:0] smp_count;

  modport master (
    output uart_in, uart_rcv,
    input  adr_ram, data_ram, we_ram, load_active, done, err, smp_count
  );

  modport slave (
    input  uart_in, uart_rcv,
    output adr_ram, data_ram, we_ram, load_active, done, err, smp_count
  );

endinterface

// File: rtl/smp_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, cleared by each byte.
// expire_o is high while the count sits at the limit and no byte is arriving.
module smp_loader_timeout
  import smp_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A byte on the expiry cycle wins, so the clear masks the pulse.
  assign expire_o = en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/smp_loader.sv
// Frame parser that assembles UART bytes into 16-bit samples and writes them
// sequentially into the playback sample RAM.
module smp_loader
  import smp_loader_pkg::*;
#(
  parameter int MAX_ADR     = MAX_ADR_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic         clk,
  input logic         rst,
  smp_loader_if.slave bus
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_ADR + 1);

  ld_state_e   state_q;
  logic [7:0]  len_h_q, lo_q, csum_q;
  logic [15:0] len_q, idx_q, adr_q, data_q, count_q;
  logic        we_q, active_q, done_q, err_q;
  logic [15:0] len_d, idx_d;
  logic [7:0]  csum_d;
  logic        expire;
  logic        timer_en;

  assign len_d    = {len_h_q, bus.uart_in};
  assign idx_d    = idx_q + 16'd1;
  assign csum_d   = csum_q + bus.uart_in;
  assign timer_en = (state_q != ST_IDLE);

  smp_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .en_i     (timer_en),
    .clr_i    (bus.uart_rcv),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_h_q  <= '0;
      lo_q     <= '0;
      csum_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      adr_q    <= '0;
      data_q   <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.uart_rcv) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.uart_in == SYNC_BYTE) begin
              state_q  <= ST_LEN_H;
              active_q <= 1'b1;
            end
          end
          ST_LEN_H: begin
            len_h_q <= bus.uart_in;
            state_q <= ST_LEN_L;
          end
          ST_LEN_L: begin
            if (len_d == 16'd0 || {1'b0, len_d} > MAX_LEN) begin
              err_q    <= 1'b1;
              active_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              len_q   <= len_d;
              idx_q   <= '0;
              csum_q  <= '0;
              state_q <= ST_DAT_L;
            end
          end
          ST_DAT_L: begin
            lo_q    <= bus.uart_in;
            csum_q  <= csum_d;
            state_q <= ST_DAT_H;
          end
          // The write is registered here so it appears one cycle after the HI byte.
          ST_DAT_H: begin
            csum_q  <= csum_d;
            we_q    <= 1'b1;
            adr_q   <= idx_q;
            data_q  <= {bus.uart_in, lo_q};
            idx_q   <= idx_d;
            state_q <= (idx_d == len_q) ? ST_CSUM : ST_DAT_L;
          end
          ST_CSUM: begin
            if (bus.uart_in == csum_q) begin
              count_q <= len_q;
              done_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
          default: begin
            active_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end else if (expire) begin
        err_q    <= 1'b1;
        active_q <= 1'b0;
        state_q  <= ST_IDLE;
      end
    end
  end

  assign bus.adr_ram     = adr_q;
  assign bus.data_ram    = data_q;
  assign bus.we_ram      = we_q;
  assign bus.load_active = active_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.smp_count   = count_q;

endmodule

// File: tb/tb_smp_loader.sv
// Scoreboard bench for smp_loader: stimulus queues expected RAM writes and
// done/err events, a negedge monitor pops and compares them.
module tb_smp_loader;
  import smp_loader_pkg::*;

  localparam int TO_CYC = 40;

  typedef struct packed {
    logic [15:0] adr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        isDone;
    logic [15:0] count;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  smp_loader_if bus();

  smp_loader #(.MAX_ADR(MAX_ADR_DEF), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wr_t         wrQ[$];
  ev_t         evQ[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] modelCount = 16'd0;
  wr_t         monWr;
  ev_t         monEv;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done/err pulse must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.we_ram) begin
        checkOutput("we_ram_expected", 32'(bus.we_ram), 32'(wrQ.size() != 0));
        if (wrQ.size() != 0) begin
          monWr = wrQ.pop_front();
          checkOutput("wr_adr", 32'(bus.adr_ram), 32'(monWr.adr));
          checkOutput("wr_data", 32'(bus.data_ram), 32'(monWr.data));
        end
      end
      if (bus.done || bus.err) begin
        checkOutput("done_err_excl", 32'(bus.done & bus.err), 32'd0);
        checkOutput("event_expected", 32'(bus.done | bus.err), 32'(evQ.size() != 0));
        checkOutput("load_active_drop", 32'(bus.load_active), 32'd0);
        if (evQ.size() != 0) begin
          monEv = evQ.pop_front();
          checkOutput("event_kind_done", 32'(bus.done), 32'(monEv.isDone));
          checkOutput("smp_count", 32'(bus.smp_count), 32'(monEv.count));
        end
      end
    end
  end

  // One strobe per call; consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b);
    bus.uart_in  = b;
    bus.uart_rcv = 1'b1;
    @(posedge clk);
    #1;
    bus.uart_rcv = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((wrQ.size() != 0 || evQ.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_writes", 32'(wrQ.size()), 32'd0);
    checkOutput("drain_events", 32'(evQ.size()), 32'd0);
    wrQ.delete();
    evQ.delete();
  endtask

  task automatic sendFrame(input logic [15:0] samples[$], input logic [7:0] csumDelta);
    logic [7:0] sum;
    int         n;
    sum = 8'd0;
    n   = samples.size();
    applyStimulus(SYNC_BYTE);
    checkOutput("load_active_rise", 32'(bus.load_active), 32'd1);
    applyStimulus(8'(n >> 8));
    applyStimulus(8'(n));
    foreach (samples[i]) begin
      wrQ.push_back('{adr: 16'(i), data: samples[i]});
      applyStimulus(samples[i][7:0]);
      applyStimulus(samples[i][15:8]);
      sum = sum + samples[i][7:0] + samples[i][15:8];
    end
    if (csumDelta == 8'd0) begin
      modelCount = 16'(n);
      evQ.push_back('{isDone: 1'b1, count: 16'(n)});
    end else begin
      evQ.push_back('{isDone: 1'b0, count: modelCount});
    end
    applyStimulus(sum + csumDelta);
    waitDrain(10);
  endtask

  task automatic sendBadLength(input logic [7:0] lenH, input logic [7:0] lenL);
    evQ.push_back('{isDone: 1'b0, count: modelCount});
    applyStimulus(SYNC_BYTE);
    applyStimulus(lenH);
    applyStimulus(lenL);
    waitDrain(10);
    checkOutput("idle_after_len_err", 32'(bus.load_active), 32'd0);
  endtask

  logic [15:0] smp[$];

  initial begin
    bus.uart_in  = 8'd0;
    bus.uart_rcv = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_adr_ram", 32'(bus.adr_ram), 32'd0);
    checkOutput("rst_data_ram", 32'(bus.data_ram), 32'd0);
    checkOutput("rst_we_ram", 32'(bus.we_ram), 32'd0);
    checkOutput("rst_load_active", 32'(bus.load_active), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_smp_count", 32'(bus.smp_count), 32'd0);
    rst = 1'b1;
    idleCycles(2);

    // Good frame, checksum 0x6A, then the same data with a wrong checksum.
    smp.delete();
    smp.push_back(16'h1234);
    smp.push_back(16'h5678);
    smp.push_back(16'h9ABC);
    sendFrame(smp, 8'd0);
    sendFrame(smp, 8'd1);

    sendBadLength(8'h00, 8'h00);
    sendBadLength(8'h31, 8'h2C);

    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    checkOutput("idle_after_garbage", 32'(bus.load_active), 32'd0);
    smp.delete();
    smp.push_back(16'hBEEF);
    smp.push_back(16'h0001);
    sendFrame(smp, 8'd0);

    smp.delete();
    for (int i = 0; i < MAX_ADR_DEF + 1; i++) smp.push_back(16'(i * 7 + 16'h1357));
    sendFrame(smp, 8'd0);

    // Stall inside a frame: no writes, one err, count kept.
    evQ.push_back('{isDone: 1'b0, count: modelCount});
    applyStimulus(SYNC_BYTE);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    idleCycles(TO_CYC + 5);
    waitDrain(3);
    checkOutput("idle_after_timeout", 32'(bus.load_active), 32'd0);

    // Byte arrives on the expiry cycle: frame continues, checksum 0x14.
    wrQ.push_back('{adr: 16'd0, data: 16'h1234});
    wrQ.push_back('{adr: 16'd1, data: 16'h5678});
    applyStimulus(SYNC_BYTE);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    idleCycles(TO_CYC);
    applyStimulus(8'h12);
    applyStimulus(8'h78);
    applyStimulus(8'h56);
    modelCount = 16'd2;
    evQ.push_back('{isDone: 1'b1, count: 16'd2});
    applyStimulus(8'h14);
    waitDrain(10);

    // Asynchronous reset between the LO and HI byte of the first sample.
    applyStimulus(SYNC_BYTE);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_adr_ram", 32'(bus.adr_ram), 32'd0);
    checkOutput("arst_data_ram", 32'(bus.data_ram), 32'd0);
    checkOutput("arst_we_ram", 32'(bus.we_ram), 32'd0);
    checkOutput("arst_load_active", 32'(bus.load_active), 32'd0);
    checkOutput("arst_done", 32'(bus.done), 32'd0);
    checkOutput("arst_err", 32'(bus.err), 32'd0);
    checkOutput("arst_smp_count", 32'(bus.smp_count), 32'd0);
    modelCount = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idleCycles(2);
    smp.delete();
    smp.push_back(16'hCAFE);
    smp.push_back(16'h0F0F);
    smp.push_back(16'h8001);
    sendFrame(smp, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
